// File: rtl/ec1_control_unit.sv
// ---------------------------------------------------------------------------
// ec1_control_unit
//   Control FSM for the EC-1 accumulator machine. It sequences
//   FETCH -> DECODE -> execute, drives every datapath strobe, and owns the
//   synchronised, edge-detected Enter key used by the IN instruction.
//
// Ports
//   clk     : system clock, rising edge
//   reset   : asynchronous active-low reset
//   Enter   : raw push-button, asynchronous to clk
//   IR7_5   : opcode field of the datapath IR
//   A       : datapath zero flag (1 = accumulator is zero)
//   IRload  : load IR from ROM[PC]
//   PCload  : load PC from the JNZ mux
//   JNZmux  : 0 = PC+1, 1 = IR[3:0]
//   INmux   : 1 = external input into A, 0 = A-1
//   Aload   : load A from the IN mux
//   OutE    : registered, sticky output-driver enable
//   Halted  : high while in HALT
//   state   : current state encoding (debug)
// ---------------------------------------------------------------------------
module ec1_control_unit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Enter,
  input  logic [2:0] IR7_5,
  input  logic       A,
  output logic       IRload,
  output logic       PCload,
  output logic       JNZmux,
  output logic       INmux,
  output logic       Aload,
  output logic       OutE,
  output logic       Halted,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_IN     = 3'b010,
    S_OUT    = 3'b011,
    S_DEC    = 3'b100,
    S_JNZ    = 3'b101,
    S_HALT   = 3'b110
  } state_e;

  state_e                 state_q;
  state_e                 state_d;
  logic                   oute_q;
  logic                   oute_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   enter_rise;

  // Enter synchroniser chain plus one history flop for rising-edge detect
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], Enter};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // A rise is only consumed in IN; elsewhere it simply ages out of hist_q
  assign enter_rise = sync_q[SYNC_STAGES-1] & ~hist_q;

  // State and sticky output-enable registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      oute_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      oute_q  <= oute_d;
    end
  end

  // Next-state and strobe decode; strobes come only from registers (and A)
  always_comb begin
    state_d = state_q;
    oute_d  = oute_q;
    IRload  = 1'b0;
    PCload  = 1'b0;
    JNZmux  = 1'b0;
    INmux   = 1'b0;
    Aload   = 1'b0;
    Halted  = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRload  = 1'b1;
        PCload  = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (IR7_5)
          3'b000:  state_d = S_IN;
          3'b001:  state_d = S_OUT;
          3'b010:  state_d = S_DEC;
          3'b011:  state_d = S_JNZ;
          3'b100:  state_d = S_HALT;
          default: state_d = S_FETCH;
        endcase
      end
      S_IN: begin
        INmux = 1'b1;
        Aload = enter_rise;
        if (enter_rise) begin
          state_d = S_FETCH;
          oute_d  = 1'b0;
        end else begin
          state_d = S_IN;
        end
      end
      S_OUT: begin
        oute_d  = 1'b1;
        state_d = S_FETCH;
      end
      S_DEC: begin
        Aload   = 1'b1;
        state_d = S_FETCH;
      end
      S_JNZ: begin
        // PC already holds PC+1 from FETCH, so only a taken jump reloads it
        JNZmux  = 1'b1;
        PCload  = ~A;
        state_d = S_FETCH;
      end
      S_HALT: begin
        Halted  = 1'b1;
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  assign OutE  = oute_q;
  assign state = state_q;

endmodule

// File: tb/tb_ec1_control_unit.sv
module tb_ec1_control_unit;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       Enter = 1'b0;
  logic [2:0] IR7_5;
  logic       A;
  logic       IRload, PCload, JNZmux, INmux, Aload, OutE, Halted;
  logic [2:0] state;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ec1_control_unit #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .Enter(Enter), .IR7_5(IR7_5), .A(A),
    .IRload(IRload), .PCload(PCload), .JNZmux(JNZmux), .INmux(INmux),
    .Aload(Aload), .OutE(OutE), .Halted(Halted), .state(state)
  );

  // ---------------- datapath environment driven by the DUT strobes ----------
  logic [7:0] rom [16];
  logic [3:0] pc;
  logic [7:0] ir;
  logic [7:0] acc;
  logic [7:0] in_val = 8'h00;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc  <= 4'd0;
      ir  <= 8'd0;
      acc <= 8'd0;
    end else begin
      if (IRload) ir <= rom[pc];
      if (PCload) pc <= JNZmux ? ir[3:0] : pc + 4'd1;
      if (Aload) acc <= INmux ? in_val : acc - 8'd1;
    end
  end

  assign IR7_5 = ir[7:5];
  assign A     = (acc == 8'd0);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- instruction-level reference model -----------------------
  typedef struct packed {
    logic [3:0] pc;
    logic [7:0] acc;
    logic       oute;
  } rec_t;

  rec_t       exp_q [$];
  logic [7:0] in_vals [64];

  // Architectural effect of each instruction; one record per instruction start
  task automatic model_run(output logic fin_oute, output logic halted);
    logic [3:0] p;
    logic [7:0] a;
    logic       o;
    logic [7:0] w;
    rec_t       r;
    int         k;
    p = 4'd0; a = 8'd0; o = 1'b0; k = 0; halted = 1'b0;
    exp_q.delete();
    for (int n = 0; n < 200 && !halted; n++) begin
      r.pc = p; r.acc = a; r.oute = o;
      exp_q.push_back(r);
      w = rom[p];
      p = p + 4'd1;
      case (w[7:5])
        3'd0: begin a = in_vals[k & 63]; k++; o = 1'b0; end
        3'd1: o = 1'b1;
        3'd2: a = a - 8'd1;
        3'd3: if (a != 8'd0) p = w[3:0];
        3'd4: halted = 1'b1;
        default: ;
      endcase
    end
    fin_oute = o;
  endtask

  // ---------------- scoreboard monitor: one record per FETCH cycle ----------
  logic mon_en = 1'b0;
  rec_t mon_r;

  always @(negedge clk) begin
    if (mon_en && state == 3'b000) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL extra_fetch: got fetch at pc=%0h expected none", pc);
      end else begin
        mon_r = exp_q.pop_front();
        chk("fetch_pc", 32'(pc), 32'(mon_r.pc));
        chk("fetch_acc", 32'(acc), 32'(mon_r.acc));
        chk("fetch_oute", 32'(OutE), 32'(mon_r.oute));
      end
    end
  end

  // ---------------- Enter driver: reacts to the IN wait state ---------------
  logic drv_en = 1'b0;
  int   in_idx = 0;
  int   d_hits;
  int   d_lat;
  logic d_got;

  initial begin
    forever begin
      @(negedge clk);
      if (!drv_en) begin
        Enter  = 1'b0;
        in_idx = 0;
      end else if (state == 3'b010) begin
        repeat ($urandom_range(0, 8)) @(negedge clk);
        if (Enter) begin
          // still held from the previous press: must not be seen as a new one
          d_hits = 0;
          repeat (SYNC + 4) begin
            @(negedge clk);
            if (Aload) d_hits++;
          end
          chk("held_no_aload", 32'(d_hits), 32'd0);
          Enter = 1'b0;
          repeat (SYNC + 2) @(negedge clk);
        end
        in_val = in_vals[in_idx & 63];
        in_idx++;
        Enter = 1'b1;
        d_lat = 0;
        d_got = 1'b0;
        while (!d_got && d_lat < SYNC + 6) begin
          @(negedge clk);
          d_lat++;
          if (Aload && INmux) d_got = 1'b1;
        end
        // Aload visible after SYNC edges, so A loads on edge SYNC+1
        chk("enter_latency", 32'(d_lat), 32'(SYNC));
        @(negedge clk);
        chk("aload_single", 32'(Aload), 32'd0);
        if ($urandom_range(0, 1) == 1) begin
          Enter = 1'b0;
          repeat (SYNC + 1) @(negedge clk);
        end
      end
    end
  end

  // ---------------- main sequence -------------------------------------------
  logic fin_oute;
  logic halts;
  int   cyc;
  int   bad;

  task automatic do_reset(input logic use_mon, input logic use_drv);
    mon_en = 1'b0;
    drv_en = 1'b0;
    reset  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_oute", 32'(OutE), 32'd0);
    @(posedge clk);
    #2;
    reset  = 1'b1;
    mon_en = use_mon;
    drv_en = use_drv;
    @(negedge clk);
    chk("first_state", 32'(state), 32'd0);
    chk("first_halted", 32'(Halted), 32'd0);
    chk("first_irload", 32'(IRload), 32'd1);
    chk("first_pcload", 32'(PCload), 32'd1);
    @(negedge clk);
    chk("second_state", 32'(state), 32'd1);
  endtask

  task automatic run_program();
    model_run(fin_oute, halts);
    do_reset(1'b1, 1'b1);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    if (halts) begin
      repeat (3) @(negedge clk);
      bad = 0;
      repeat (50) begin
        @(negedge clk);
        if (state !== 3'b110 || Halted !== 1'b1 || OutE !== fin_oute ||
            IRload || PCload || Aload) bad++;
      end
      chk("halt_hold", 32'(bad), 32'd0);
    end
    mon_en = 1'b0;
    drv_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic gen_random_program();
    logic [7:0] w;
    int         r;
    for (int a = 0; a < 15; a++) begin
      w = 8'($urandom_range(0, 255));
      r = $urandom_range(0, 9);
      case (r)
        0, 1: w[7:5] = 3'd0;
        2, 3: w[7:5] = 3'd1;
        4, 5: w[7:5] = 3'd2;
        6, 7: begin
          // forward-only jumps keep every random program terminating
          w[7:5] = 3'd3;
          w[3:0] = 4'($urandom_range(a + 1, 15));
        end
        8: w[7:5] = 3'($urandom_range(5, 7));
        default: w[7:5] = 3'd4;
      endcase
      rom[a] = w;
    end
    rom[15] = 8'h80 | 8'($urandom_range(0, 31));
    for (int i = 0; i < 64; i++) in_vals[i] = 8'($urandom_range(0, 255));
    in_vals[1] = 8'h00;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 8'h80;
    for (int i = 0; i < 64; i++) in_vals[i] = 8'h00;

    // IN, OUT, HALT
    rom[0] = 8'h00; rom[1] = 8'h20; rom[2] = 8'h80;
    in_vals[0] = 8'h05;
    run_program();

    // countdown: IN, OUT, DEC, JNZ 1, HALT with input 3
    rom[0] = 8'h00; rom[1] = 8'h20; rom[2] = 8'h40; rom[3] = 8'h61; rom[4] = 8'h80;
    in_vals[0] = 8'h03;
    run_program();

    // undefined opcodes act as NOP
    rom[0] = 8'hA0; rom[1] = 8'hC5; rom[2] = 8'hE7; rom[3] = 8'h20; rom[4] = 8'hA3; rom[5] = 8'h80;
    run_program();

    for (int k = 0; k < 10; k++) begin
      gen_random_program();
      run_program();
    end

    // asynchronous reset while waiting in IN with OutE set
    rom[0] = 8'h20; rom[1] = 8'h00; rom[2] = 8'h80;
    do_reset(1'b0, 1'b0);
    cyc = 0;
    while (state !== 3'b010 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("in_reached", 32'(state), 32'd2);
    repeat (5) @(negedge clk);
    chk("in_wait_state", 32'(state), 32'd2);
    chk("in_wait_oute", 32'(OutE), 32'd1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("async_rst_state", 32'(state), 32'd0);
    chk("async_rst_oute", 32'(OutE), 32'd0);
    #20;
    reset = 1'b1;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
